// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//   Shares a single-port framebuffer RAM (32-bit words, 4 x 8-bit pixels per
//   word) between VGA scanout and N_REQ drawing writers. Scanout owns every
//   4th pixel clock of the active region (hcount[1:0]==0); all other cycles,
//   including the whole of blanking, are handed to the writers round-robin.
//   The sync and active strobes are delayed LAT clocks so they stay aligned
//   with the pixel stream.
//
// Ports
//   i_pix_clk, i_reset_n        pixel clock, async active-low reset
//   i_hcount, i_vcount          raster position from the timing generator
//   i_active_in/hsync_in/vsync_in   timing strobes
//   i_wr_req/addr/data          per-client write request (level, held to ack)
//   o_wr_ack                    one-cycle accept pulse per client
//   o_ram_addr/we/wdata         registered RAM command
//   i_ram_rdata                 RAM read data, valid 1 clock after o_ram_addr
//   o_pixel                     pixel stream, 0 outside the active region
//   o_active_out/hsync_out/vsync_out   strobes delayed by LAT clocks
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 17,
    parameter int N_REQ    = 2,
    parameter int LAT      = 3
) (
    input  logic                    i_pix_clk,
    input  logic                    i_reset_n,
    input  logic [9:0]              i_hcount,
    input  logic [9:0]              i_vcount,
    input  logic                    i_active_in,
    input  logic                    i_hsync_in,
    input  logic                    i_vsync_in,
    input  logic [N_REQ-1:0]        i_wr_req,
    input  logic [N_REQ*ADDR_W-1:0] i_wr_addr,
    input  logic [N_REQ*32-1:0]     i_wr_data,
    output logic [N_REQ-1:0]        o_wr_ack,
    output logic [ADDR_W-1:0]       o_ram_addr,
    output logic                    o_ram_we,
    output logic [31:0]             o_ram_wdata,
    input  logic [31:0]             i_ram_rdata,
    output logic [7:0]              o_pixel,
    output logic                    o_active_out,
    output logic                    o_hsync_out,
    output logic                    o_vsync_out
);

    localparam int unsigned LINE_W = H_ACTIVE / 4;
    localparam int unsigned WORDS  = H_ACTIVE * V_ACTIVE / 4;
    localparam int          PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Registered state
    logic [N_REQ-1:0]  r_wr_ack;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [31:0]       r_ram_wdata;
    logic [PW-1:0]     r_ptr;
    logic [1:0]        r_disp_pipe;
    logic [31:0]       r_shift;
    logic [LAT-1:0]    r_act_pipe;
    logic [LAT-1:0]    r_hs_pipe;
    logic [LAT-1:0]    r_vs_pipe;

    // Combinational
    logic              w_disp;
    logic [ADDR_W-1:0] w_disp_addr;
    logic [N_REQ-1:0]  w_elig;
    logic [PW:0]       w_cand;
    logic              w_gnt_vld;
    logic [PW-1:0]     w_gnt_idx;
    logic [N_REQ-1:0]  w_gnt_oh;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [31:0]       w_gnt_data;
    logic              w_in_range;
    logic [PW:0]       w_nxt_sum;
    logic [PW-1:0]     w_ptr_nxt;

    assign w_disp      = i_active_in && (i_hcount[1:0] == 2'b00);
    assign w_disp_addr = ADDR_W'(32'(i_vcount) * LINE_W + 32'(i_hcount[9:2]));

    // A client acked this cycle may still show req high for the same write.
    assign w_elig = i_wr_req & ~r_wr_ack;

    // Round-robin search from r_ptr; descending loop so the nearest wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_cand >= (PW+1)'(N_REQ))
                w_cand = w_cand - (PW+1)'(N_REQ);
            if (w_elig[w_cand[PW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand[PW-1:0];
            end
        end
    end

    always_comb begin
        w_gnt_oh   = '0;
        w_gnt_addr = '0;
        w_gnt_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_vld && (w_gnt_idx == PW'(i))) begin
                w_gnt_oh[i] = 1'b1;
                w_gnt_addr  = i_wr_addr[i*ADDR_W +: ADDR_W];
                w_gnt_data  = i_wr_data[i*32 +: 32];
            end
        end
    end

    assign w_in_range = (32'(w_gnt_addr) < WORDS);
    assign w_nxt_sum  = {1'b0, w_gnt_idx} + (PW+1)'(1);
    assign w_ptr_nxt  = (w_nxt_sum >= (PW+1)'(N_REQ)) ? '0 : w_nxt_sum[PW-1:0];

    // RAM command / arbitration
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ack    <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
            r_ptr       <= '0;
        end else begin
            r_wr_ack <= '0;
            r_ram_we <= 1'b0;
            if (w_disp) begin
                r_ram_addr <= w_disp_addr;
            end else if (w_gnt_vld) begin
                r_wr_ack <= w_gnt_oh;
                r_ptr    <= w_ptr_nxt;
                // Out-of-range writes are acked so the client moves on, but
                // never reach the RAM.
                if (w_in_range) begin
                    r_ram_we    <= 1'b1;
                    r_ram_addr  <= w_gnt_addr;
                    r_ram_wdata <= w_gnt_data;
                end
            end
        end
    end

    // Pixel pipeline: slot in n, address out in n+1, data in n+2, loaded at
    // the end of n+2, then shifted a byte per clock until the next load.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_disp_pipe <= '0;
            r_shift     <= '0;
            r_act_pipe  <= '0;
            r_hs_pipe   <= '0;
            r_vs_pipe   <= '0;
        end else begin
            r_disp_pipe <= {r_disp_pipe[0], w_disp};
            if (r_disp_pipe[1])
                r_shift <= i_ram_rdata;
            else
                r_shift <= {8'h00, r_shift[31:8]};
            r_act_pipe <= {r_act_pipe[LAT-2:0], i_active_in};
            r_hs_pipe  <= {r_hs_pipe[LAT-2:0], i_hsync_in};
            r_vs_pipe  <= {r_vs_pipe[LAT-2:0], i_vsync_in};
        end
    end

    assign o_wr_ack     = r_wr_ack;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_we     = r_ram_we;
    assign o_ram_wdata  = r_ram_wdata;
    assign o_active_out = r_act_pipe[LAT-1];
    assign o_hsync_out  = r_hs_pipe[LAT-1];
    assign o_vsync_out  = r_vs_pipe[LAT-1];
    assign o_pixel      = o_active_out ? r_shift[7:0] : 8'h00;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
    localparam int N     = 2;
    localparam int AW    = 17;
    localparam int LINE  = 160;
    localparam int WORDS = 76800;
    localparam int HA    = 640;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [9:0]      hcount = '0;
    logic [9:0]      vcount = '0;
    logic            act_in = 1'b0;
    logic            hs_in  = 1'b0;
    logic            vs_in  = 1'b0;
    logic [N-1:0]    wr_req = '0;
    logic [N*AW-1:0] wr_addr = '0;
    logic [N*32-1:0] wr_data = '0;
    logic [N-1:0]    wr_ack;
    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_rdata = '0;
    logic [7:0]      pixel;
    logic            act_out, hs_out, vs_out;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .i_pix_clk(clk), .i_reset_n(rst_n),
        .i_hcount(hcount), .i_vcount(vcount),
        .i_active_in(act_in), .i_hsync_in(hs_in), .i_vsync_in(vs_in),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_wr_ack(wr_ack),
        .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata),
        .o_pixel(pixel), .o_active_out(act_out),
        .o_hsync_out(hs_out), .o_vsync_out(vs_out)
    );

    // Framebuffer contents as a fixed function of the word address.
    function automatic logic [31:0] memf(input logic [AW-1:0] a);
        return 32'h44332211 + 32'(a) * 32'h01010101;
    endfunction

    // Synchronous-read RAM: data valid one clock after the address.
    always @(posedge clk) ram_rdata <= memf(ram_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [N-1:0]  ack;
        logic          we;
        logic          chk_addr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } bus_exp_t;

    typedef struct {
        int         due;
        logic       act, hs, vs;
        logic [7:0] pix;
        logic       pchk;
    } pix_exp_t;

    bus_exp_t bq[$];
    pix_exp_t pq[$];
    bus_exp_t be;
    pix_exp_t pe;

    int n_chk  = 0;
    int n_fail = 0;
    int ack0_tot = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Client state and reference model state
    int            cnt   [N];
    logic [AW-1:0] caddr [N];
    logic [31:0]   cdata [N];
    int            m_ptr  = 0;
    logic [N-1:0]  m_ack  = '0;
    bit            pix_ok = 1'b0;

    task automatic req_start(input int i, input int n, input int a, input logic [31:0] d);
        cnt[i]   = n;
        caddr[i] = AW'(a);
        cdata[i] = d;
    endtask

    // One pixel clock: update clients, drive timing, push expectations.
    task automatic step(input int h, input int v, input logic act, input logic hs, input logic vs);
        bus_exp_t   e;
        pix_exp_t   p;
        bit         elig [N];
        int         g;
        logic [31:0] w;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (wr_ack[i] && cnt[i] > 0) begin
                cnt[i]--;
                caddr[i] = caddr[i] + 1'b1;
                cdata[i] = cdata[i] + 32'h01010101;
            end
            wr_req[i]            = (cnt[i] > 0);
            wr_addr[i*AW +: AW]  = caddr[i];
            wr_data[i*32 +: 32]  = cdata[i];
        end
        hcount = 10'(h);
        vcount = 10'(v);
        act_in = act;
        hs_in  = hs;
        vs_in  = vs;

        e.due = cyc + 1; e.ack = '0; e.we = 1'b0; e.chk_addr = 1'b0; e.addr = '0; e.data = '0;
        if (act && (h % 4 == 0)) begin
            e.chk_addr = 1'b1;
            e.addr     = AW'(v * LINE + h / 4);
            pix_ok     = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) elig[i] = wr_req[i] && !m_ack[i];
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) begin
                e.ack      = N'(1) << g;
                e.we       = (int'(caddr[g]) < WORDS);
                e.chk_addr = e.we;
                e.addr     = caddr[g];
                e.data     = cdata[g];
                m_ptr      = (g + 1) % N;
            end
        end
        m_ack = e.ack;
        bq.push_back(e);

        p.due = cyc + 3; p.act = act; p.hs = hs; p.vs = vs;
        w = memf(AW'(v * LINE + h / 4));
        p.pix  = act ? w[8*(h%4) +: 8] : 8'h00;
        p.pchk = !act || pix_ok;
        pq.push_back(p);
    endtask

    task automatic line(input int v, input int n_act, input int n_blank);
        for (int h = 0; h < n_act; h++) step(h, v, 1'b1, 1'b0, 1'b0);
        for (int b = 0; b < n_blank; b++) step(HA + b, v, 1'b0, (b >= 1 && b < 4), (v == 2));
    endtask

    task automatic blank(input int n, input int v);
        for (int b = 0; b < n; b++) step(HA + 16 + b, v, 1'b0, (b % 3 == 0), 1'b0);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_ram_addr"},  ram_addr,  '0);
        chk({pfx, "_ram_we"},    ram_we,    '0);
        chk({pfx, "_ram_wdata"}, ram_wdata, '0);
        chk({pfx, "_wr_ack"},    wr_ack,    '0);
        chk({pfx, "_pixel"},     pixel,     '0);
        chk({pfx, "_act_out"},   act_out,   '0);
        chk({pfx, "_hs_out"},    hs_out,    '0);
        chk({pfx, "_vs_out"},    vs_out,    '0);
    endtask

    task automatic reset_mid();
        @(posedge clk); #1;
        hcount = 10'(9);
        rst_n  = 1'b0;
        bq.delete();
        pq.delete();
        m_ptr  = 0;
        m_ack  = '0;
        pix_ok = 1'b0;
        #1;
        chk_all_zero("mid_rst");
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (rst_n) begin
            while (bq.size() > 0 && bq[0].due <= cyc) begin
                be = bq.pop_front();
                chk("wr_ack", wr_ack, be.ack);
                chk("ram_we", ram_we, be.we);
                if (be.chk_addr) chk("ram_addr", ram_addr, be.addr);
                if (be.we)       chk("ram_wdata", ram_wdata, be.data);
            end
            while (pq.size() > 0 && pq[0].due <= cyc) begin
                pe = pq.pop_front();
                chk("active_out", act_out, pe.act);
                chk("hsync_out", hs_out, pe.hs);
                chk("vsync_out", vs_out, pe.vs);
                if (pe.pchk) chk("pixel", pixel, pe.pix);
            end
            if (wr_ack[0]) ack0_tot++;
        end
    end

    int ack0_base;

    initial begin
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; caddr[i] = '0; cdata[i] = '0;
        end
        #1 rst_n = 1'b0;
        #1 chk_all_zero("rst");
        repeat (2) @(posedge clk);

        // Display addressing and pixel stream, lines 0 and 1
        line(0, 16, 8);
        line(1, 16, 8);

        // Single write raised in a display slot
        req_start(0, 1, 5, 32'hA5A5A5A5);
        line(2, 16, 8);

        // Two clients contending in blanking, then in the active region
        req_start(0, 4, 100, 32'h10000000);
        req_start(1, 4, 200, 32'h20000000);
        blank(10, 2);
        req_start(0, 6, 300, 32'h30000000);
        req_start(1, 6, 400, 32'h40000000);
        line(3, 16, 4);

        // Out-of-range write: acked, not written
        req_start(1, 1, WORDS, 32'hDEADBEEF);
        blank(4, 3);

        // Reset with a pending request mid-line
        line(4, 8, 0);
        req_start(0, 1, 500, 32'h50505050);
        step(8, 4, 1'b1, 1'b0, 1'b0);
        reset_mid();
        repeat (2) @(posedge clk);
        ack0_base = ack0_tot;
        for (int h = 12; h < 16; h++) step(h, 4, 1'b1, 1'b0, 1'b0);
        blank(6, 4);

        repeat (4) @(posedge clk);
        #1;
        chk("rst_single_ack", ack0_tot - ack0_base, 1);
        chk("bus_q_drained", bq.size(), 0);
        chk("pix_q_drained", pq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
